// File: rtl/ctrl_mc_if.sv
// ctrl_mc_if -- bundle between the multi-cycle controller and its datapath.
//   Datapath -> controller : OP, Fun (instruction fields), zero (ALU flag),
//                            MIO_ready (memory handshake)
//   Controller -> datapath : write enables, mux selects, ALU_Control,
//                            state_out (current state code), err (sticky fault)
// modport master : the controller side.  modport slave : the datapath side.
interface ctrl_mc_if;
    logic [5:0] OP;
    logic [5:0] Fun;
    logic       zero;
    logic       MIO_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALU_Control;
    logic [3:0] state_out;
    logic       err;

    modport master (
        input  OP, Fun, zero, MIO_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_Control, state_out, err
    );

    modport slave (
        output OP, Fun, zero, MIO_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_Control, state_out, err
    );
endinterface

// File: rtl/ctrl_mc.sv
// ctrl_mc -- multi-cycle MIPS-style Moore controller with memory-wait watchdog.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ctrl_mc_if.master (instruction fields, zero, MIO_ready in;
//          datapath enables/selects, state_out, err out)
// Parameter WAIT_LIMIT: consecutive not-ready cycles tolerated in IF/MRD/MWR
//   before faulting to ERR; 0 disables the watchdog.
// Optional feature macro CTRL_BNE_EN: decode bne (OP=000101) into BR with
//   PCWrite=~zero; without it bne is an illegal opcode.
module ctrl_mc #(
    parameter logic [7:0] WAIT_LIMIT = 8'd16
) (
    input  logic      clk,
    input  logic      rst,
    ctrl_mc_if.master bus
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_MADR = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4,
        S_MWR = 4'd5, S_REXE = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9,
        S_IEXE = 4'd10, S_IWB = 4'd11, S_ERR = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    // Registered, state-only outputs plus flags for the few outputs that
    // must follow an input combinationally (MIO_ready in IF, zero in BR).
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_ctl;
        logic       in_if;
        logic       in_br;
        logic       br_ne;
        logic       pc_jump;
    } ctl_t;

    localparam ctl_t CTL_IF = '{mem_read: 1'b1, alu_src_b: 2'b01, alu_ctl: 3'b010,
                                in_if: 1'b1, default: '0};

    state_t     state, nxt;
    logic [7:0] wait_cnt, wait_d;
    logic       err_q;
    ctl_t       ctl_q, ctl_d;
    logic       r_ok, wait_st, timeout;
    logic [2:0] r_alu, i_alu;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = 3'b010;
        case (bus.Fun)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b111;
            6'b100111: r_alu = 3'b100;
            6'b100110: r_alu = 3'b011;
            6'b000010: r_alu = 3'b101;
            default:   r_ok  = 1'b0;
        endcase
        case (bus.OP)
            OP_ANDI: i_alu = 3'b000;
            OP_ORI:  i_alu = 3'b001;
            OP_SLTI: i_alu = 3'b111;
            default: i_alu = 3'b010;
        endcase
    end

    // Watchdog trips on the not-ready cycle that would make the count hit
    // the limit, so the FSM never spends a further cycle waiting.
    assign wait_st = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
    assign timeout = wait_st && !bus.MIO_ready && (WAIT_LIMIT != 8'd0) &&
                     ({1'b0, wait_cnt} + 9'd1 == {1'b0, WAIT_LIMIT});

    always_comb begin
        nxt = state;
        case (state)
            S_IF:   if (bus.MIO_ready) nxt = S_ID;   else if (timeout) nxt = S_ERR;
            S_ID: begin
                case (bus.OP)
                    OP_LW, OP_SW: nxt = S_MADR;
                    OP_R:         nxt = r_ok ? S_REXE : S_ERR;
                    OP_BEQ:       nxt = S_BR;
`ifdef CTRL_BNE_EN
                    OP_BNE:       nxt = S_BR;
`endif
                    OP_J:         nxt = S_J;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_IEXE;
                    default:      nxt = S_ERR;
                endcase
            end
            S_MADR: nxt = (bus.OP == OP_SW) ? S_MWR : S_MRD;
            S_MRD:  if (bus.MIO_ready) nxt = S_MWB;  else if (timeout) nxt = S_ERR;
            S_MWR:  if (bus.MIO_ready) nxt = S_IF;   else if (timeout) nxt = S_ERR;
            S_REXE: nxt = S_RWB;
            S_IEXE: nxt = S_IWB;
            S_MWB, S_RWB, S_BR, S_J, S_IWB: nxt = S_IF;
            default: nxt = S_ERR;
        endcase

        // Counter only survives a cycle that stays in the same wait state.
        if (wait_st && !bus.MIO_ready && nxt == state)
            wait_d = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        else
            wait_d = 8'd0;
    end

    // Outputs are decoded from the next state and registered with it.
    always_comb begin
        ctl_d = '0;
        case (nxt)
            S_IF:   ctl_d = CTL_IF;
            S_ID:   begin ctl_d.alu_src_b = 2'b11; ctl_d.alu_ctl = 3'b010; end
            S_MADR: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10; ctl_d.alu_ctl = 3'b010; end
            S_MRD:  begin ctl_d.mem_read = 1'b1; ctl_d.iord = 1'b1; end
            S_MWB:  begin ctl_d.memto_reg = 1'b1; ctl_d.reg_write = 1'b1; end
            S_MWR:  begin ctl_d.mem_write = 1'b1; ctl_d.iord = 1'b1; end
            S_REXE: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_ctl = r_alu; end
            S_RWB:  begin ctl_d.reg_dst = 1'b1; ctl_d.reg_write = 1'b1; end
            S_BR: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_ctl   = 3'b110;
                ctl_d.pc_source = 2'b01;
                ctl_d.in_br     = 1'b1;
`ifdef CTRL_BNE_EN
                ctl_d.br_ne     = (bus.OP == OP_BNE);
`endif
            end
            S_J:    begin ctl_d.pc_source = 2'b10; ctl_d.pc_jump = 1'b1; end
            S_IEXE: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10; ctl_d.alu_ctl = i_alu; end
            S_IWB:  ctl_d.reg_write = 1'b1;
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
            ctl_q    <= CTL_IF;
        end else begin
            state    <= nxt;
            wait_cnt <= wait_d;
            err_q    <= err_q | (nxt == S_ERR);
            ctl_q    <= ctl_d;
        end
    end

    // rst gates the input-following enables so nothing writes while held in reset.
    assign bus.PCWrite     = rst & (ctl_q.pc_jump | (ctl_q.in_if & bus.MIO_ready) |
                                    (ctl_q.in_br & (bus.zero ^ ctl_q.br_ne)));
    assign bus.IRWrite     = rst & ctl_q.in_if & bus.MIO_ready;
    assign bus.MemRead     = ctl_q.mem_read;
    assign bus.MemWrite    = ctl_q.mem_write;
    assign bus.IorD        = ctl_q.iord;
    assign bus.RegWrite    = ctl_q.reg_write;
    assign bus.RegDst      = ctl_q.reg_dst;
    assign bus.MemtoReg    = ctl_q.memto_reg;
    assign bus.ALUSrcA     = ctl_q.alu_src_a;
    assign bus.ALUSrcB     = ctl_q.alu_src_b;
    assign bus.PCSource    = ctl_q.pc_source;
    assign bus.ALU_Control = ctl_q.alu_ctl;
    assign bus.state_out   = state;
    assign bus.err         = err_q;
endmodule
